// File: rtl/dtw_pkg.sv
// Shared DTW definitions: result record word layout and reader FSM encoding.
package dtw_pkg;

  // Word order of a result record as serialised by the DTW core
  localparam int unsigned RES_W_QID = 0;
  localparam int unsigned RES_W_POS = 1;
  localparam int unsigned RES_W_VAL = 2;
  localparam int unsigned RES_WORDS = 3;

  // Result reader FSM encoding
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } rr_state_e;

endpackage : dtw_pkg

// File: rtl/dtw_result_reader.sv
// Drains 3-word DTW result records from the sink FIFO and presents them as
// one parallel record over a valid/ready handshake, with match flag, record
// counter and sticky framing-error flag.
module dtw_result_reader
  import dtw_pkg::*;
#(
  parameter int unsigned axi_dwidth = 32,
  parameter int unsigned dtw_dwidth = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear_stats,
  input  logic [dtw_dwidth-1:0] match_threshold,
  output logic                  sink_fifo_rden,
  input  logic                  sink_fifo_empty,
  input  logic [axi_dwidth-1:0] sink_fifo_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [axi_dwidth-1:0] res_qid,
  output logic [axi_dwidth-1:0] res_position,
  output logic [dtw_dwidth-1:0] res_minval,
  output logic                  res_match,
  output logic [CNT_WIDTH-1:0]  res_count,
  output logic                  frame_err
);

  localparam int unsigned IDX_W = 2;
  localparam logic [IDX_W-1:0] SLOT_QID = IDX_W'(RES_W_QID);
  localparam logic [IDX_W-1:0] SLOT_POS = IDX_W'(RES_W_POS);
  localparam logic [IDX_W-1:0] SLOT_VAL = IDX_W'(RES_W_VAL);
  localparam logic [IDX_W-1:0] N_WORDS  = IDX_W'(RES_WORDS);

  rr_state_e        state_q, state_d;
  logic [IDX_W-1:0] issue_cnt_q;
  logic [IDX_W-1:0] cap_cnt_q;
  logic             rd_pend_q;
  logic             accept_c;
  logic             last_cap_c;

  assign res_valid  = (state_q == ST_PRESENT);
  assign accept_c   = res_valid && res_ready;
  assign last_cap_c = rd_pend_q && (cap_cnt_q == SLOT_VAL);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and FIFO read strobe; reads only while collecting, never on empty
  always_comb begin
    state_d        = state_q;
    sink_fifo_rden = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        sink_fifo_rden = enable && !sink_fifo_empty && (issue_cnt_q < N_WORDS);
        if (last_cap_c) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (accept_c) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Issue/capture bookkeeping; FIFO data lands one cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
    end else begin
      rd_pend_q <= sink_fifo_rden;
      if (accept_c) begin
        issue_cnt_q <= '0;
        cap_cnt_q   <= '0;
      end else begin
        if (sink_fifo_rden) issue_cnt_q <= issue_cnt_q + IDX_W'(1);
        if (rd_pend_q)      cap_cnt_q   <= cap_cnt_q + IDX_W'(1);
      end
    end
  end

  // Record slots; held while presenting because no capture can occur then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_qid      <= '0;
      res_position <= '0;
      res_minval   <= '0;
      res_match    <= 1'b0;
    end else if (rd_pend_q) begin
      case (cap_cnt_q)
        SLOT_QID: res_qid      <= sink_fifo_data;
        SLOT_POS: res_position <= sink_fifo_data;
        SLOT_VAL: begin
          res_minval <= sink_fifo_data[dtw_dwidth-1:0];
          res_match  <= (sink_fifo_data[dtw_dwidth-1:0] <= match_threshold);
        end
        default: ;
      endcase
    end
  end

  // Statistics: saturating record count and sticky framing error, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= '0;
      frame_err <= 1'b0;
    end else if (clear_stats) begin
      res_count <= '0;
      frame_err <= 1'b0;
    end else begin
      if (accept_c && (res_count != '1)) res_count <= res_count + CNT_WIDTH'(1);
      if (last_cap_c && (|sink_fifo_data[axi_dwidth-1:dtw_dwidth])) frame_err <= 1'b1;
    end
  end

endmodule : dtw_result_reader

// File: tb/tb_dtw_result_reader.sv
// Directed bench for dtw_result_reader with a FIFO model and record scoreboard.
module tb_dtw_result_reader;

  typedef struct packed {
    logic [31:0] qid;
    logic [31:0] pos;
    logic [15:0] minval;
    logic        match;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_stats = 1'b0;
  logic [15:0] match_threshold = 16'h0060;
  logic        sink_fifo_rden;
  logic        sink_fifo_empty;
  logic [31:0] sink_fifo_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_qid;
  logic [31:0] res_position;
  logic [15:0] res_minval;
  logic        res_match;
  logic [31:0] res_count;
  logic        frame_err;

  dtw_result_reader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .clear_stats     (clear_stats),
    .match_threshold (match_threshold),
    .sink_fifo_rden  (sink_fifo_rden),
    .sink_fifo_empty (sink_fifo_empty),
    .sink_fifo_data  (sink_fifo_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_qid         (res_qid),
    .res_position    (res_position),
    .res_minval      (res_minval),
    .res_match       (res_match),
    .res_count       (res_count),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  // FIFO model: writer index owned by the stimulus, reader index by the pop process
  logic [31:0] fifo_mem [0:255];
  int unsigned push_cnt = 0;
  int unsigned pop_cnt = 0;
  int unsigned rden_empty_cnt = 0;

  assign sink_fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (sink_fifo_rden) begin
      if (push_cnt == pop_cnt) rden_empty_cnt <= rden_empty_cnt + 1;
      sink_fifo_data <= fifo_mem[pop_cnt[7:0]];
      pop_cnt        <= pop_cnt + 1;
    end
  end

  rec_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc;
  int          stable_bad;
  int unsigned base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[push_cnt[7:0]] = w;
    push_cnt++;
  endtask

  task automatic sb_push(input logic [31:0] q, input logic [31:0] p, input logic [31:0] v);
    rec_t e;
    e.qid    = q;
    e.pos    = p;
    e.minval = v[15:0];
    e.match  = (v[15:0] <= match_threshold);
    sb_q.push_back(e);
  endtask

  task automatic push_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] v);
    sb_push(q, p, v);
    push_word(q);
    push_word(p);
    push_word(v);
  endtask

  // Counts negedges until res_valid is seen, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (res_valid) break;
    end
    chk("valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic check_rec(input string tag);
    rec_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_qid"},    64'(res_qid),      64'(e.qid));
      chk({tag, "_pos"},    64'(res_position), 64'(e.pos));
      chk({tag, "_minval"}, 64'(res_minval),   64'(e.minval));
      chk({tag, "_match"},  64'(res_match),    64'(e.match));
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  64'(res_valid),    64'd0);
    chk({tag, "_qid"},    64'(res_qid),      64'd0);
    chk({tag, "_pos"},    64'(res_position), 64'd0);
    chk({tag, "_minval"}, 64'(res_minval),   64'd0);
    chk({tag, "_match"},  64'(res_match),    64'd0);
    chk({tag, "_count"},  64'(res_count),    64'd0);
    chk({tag, "_ferr"},   64'(frame_err),    64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rden", 64'(sink_fifo_rden), 64'd0);
    chk_reset_outputs("rst");
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Single record, consumer always ready; valid four cycles after first strobe
    res_ready = 1'b1;
    push_rec(32'h0000_0007, 32'h0000_1A2B, 32'h0000_0050);
    wait_valid(cyc);
    chk("t1_latency", 64'(cyc), 64'd4);
    check_rec("t1");
    @(negedge clk);
    res_ready = 1'b0;
    chk("t1_count", 64'(res_count), 64'd1);
    chk("t1_valid_drop", 64'(res_valid), 64'd0);

    // Back-to-back records with a stalled consumer: hold, no prefetch
    base = pop_cnt;
    push_rec(32'h11, 32'h111, 32'h70);
    push_rec(32'h12, 32'h222, 32'h10);
    wait_valid(cyc);
    chk("t2_latency", 64'(cyc), 64'd4);
    stable_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_qid !== sb_q[0].qid || res_position !== sb_q[0].pos ||
          res_minval !== sb_q[0].minval || res_match !== sb_q[0].match)
        stable_bad++;
    end
    chk("t2_stable", 64'(stable_bad), 64'd0);
    chk("t2_reads_held", 64'(pop_cnt - base), 64'd3);
    check_rec("t2a");
    accept();
    // Four edges after the accepting edge the next record is valid
    wait_valid(cyc);
    chk("t2_gap", 64'(cyc), 64'd4);
    check_rec("t2b");
    accept();
    chk("t2_count", 64'(res_count), 64'd3);

    // FIFO starved after word 0
    base = pop_cnt;
    sb_push(32'h21, 32'h2222, 32'h60);
    push_word(32'h21);
    repeat (5) @(negedge clk);
    chk("t3_reads_starved", 64'(pop_cnt - base), 64'd1);
    chk("t3_no_valid", 64'(res_valid), 64'd0);
    push_word(32'h2222);
    push_word(32'h60);
    wait_valid(cyc);
    check_rec("t3");
    chk("t3_reads", 64'(pop_cnt - base), 64'd3);
    accept();

    // Enable dropped after the first strobe, partial record resumed
    base = pop_cnt;
    push_rec(32'h31, 32'h3333, 32'h61);
    @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_reads_paused", 64'(pop_cnt - base), 64'd1);
    chk("t4_no_valid", 64'(res_valid), 64'd0);
    enable = 1'b1;
    wait_valid(cyc);
    check_rec("t4");
    chk("t4_reads", 64'(pop_cnt - base), 64'd3);
    accept();

    // Framing error is sticky; clear_stats resets stats
    match_threshold = 16'h0004;
    push_rec(32'h41, 32'h4444, 32'h0001_0005);
    wait_valid(cyc);
    check_rec("t5a");
    chk("t5_ferr_set", 64'(frame_err), 64'd1);
    accept();
    push_rec(32'h42, 32'h4545, 32'h0000_0003);
    wait_valid(cyc);
    check_rec("t5b");
    chk("t5_ferr_sticky", 64'(frame_err), 64'd1);
    accept();
    chk("t5_count", 64'(res_count), 64'd7);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("t5_ferr_clr", 64'(frame_err), 64'd0);
    chk("t5_count_clr", 64'(res_count), 64'd0);

    // clear_stats wins over a same-cycle accept
    push_rec(32'h51, 32'h5555, 32'h0000_0004);
    wait_valid(cyc);
    check_rec("t5c");
    res_ready   = 1'b1;
    clear_stats = 1'b1;
    @(negedge clk);
    res_ready   = 1'b0;
    clear_stats = 1'b0;
    chk("t5_clr_prio", 64'(res_count), 64'd0);
    chk("t5_clr_valid", 64'(res_valid), 64'd0);

    // Reset after two captures drops the partial record
    match_threshold = 16'h0060;
    push_word(32'h61);
    push_word(32'h62);
    push_word(32'h63);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_rst");
    rst_n = 1'b1;
    @(negedge clk);
    push_rec(32'h71, 32'h7777, 32'h20);
    wait_valid(cyc);
    chk("t6_latency", 64'(cyc), 64'd4);
    check_rec("t6");
    accept();
    chk("t6_count", 64'(res_count), 64'd1);

    // Global checks
    repeat (2) @(negedge clk);
    chk("no_rden_when_empty", 64'(rden_empty_cnt), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_dtw_result_reader
